// File: rtl/collide_pkg.sv
// Shared types and encodings for the sprite collision monitor.
package collide_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    CONTACT = 2'd2
  } state_t;

  localparam logic [1:0] SIDE_TOP    = 2'd0;
  localparam logic [1:0] SIDE_BOTTOM = 2'd1;
  localparam logic [1:0] SIDE_LEFT   = 2'd2;
  localparam logic [1:0] SIDE_RIGHT  = 2'd3;

  typedef enum logic [1:0] {
    TOP    = SIDE_TOP,
    BOTTOM = SIDE_BOTTOM,
    LEFT   = SIDE_LEFT,
    RIGHT  = SIDE_RIGHT
  } side_t;

endpackage

// File: rtl/collision_monitor_if.sv
// Position/size bus between the sprite producers and the collision monitor.
interface collision_monitor_if #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 8
);
  // No handshake: the monitor samples every field on each frame_clk edge while
  // enable is high; the producer must hold a coherent frame across that edge.
  logic               enable;
  logic               clear_count;
  logic [COORD_W-1:0] ax, ay, as;
  logic [COORD_W-1:0] bx, by, bs;
  logic               overlap;
  logic               in_contact;
  logic               enter_pulse;
  logic               exit_pulse;
  logic [CNT_W-1:0]   hit_count;
  logic [1:0]         hit_side;

  modport master (
    output enable, clear_count, ax, ay, as, bx, by, bs,
    input  overlap, in_contact, enter_pulse, exit_pulse, hit_count, hit_side
  );

  modport slave (
    input  enable, clear_count, ax, ay, as, bx, by, bs,
    output overlap, in_contact, enter_pulse, exit_pulse, hit_count, hit_side
  );
endinterface

// File: rtl/axis_overlap.sv
// One-axis overlap test: |a-b| < sa+sb. With COLLIDE_SIDE_EN it also reports
// penetration depth and ordering for side classification.
module axis_overlap #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] i_a,
  input  logic [COORD_W-1:0] i_b,
  input  logic [COORD_W-1:0] i_sa,
  input  logic [COORD_W-1:0] i_sb,
  output logic               o_hit
`ifdef COLLIDE_SIDE_EN
  ,
  output logic [COORD_W:0]   o_pen,
  output logic               o_a_lt_b
`endif
);

  logic [COORD_W:0] w_d;
  logic [COORD_W:0] w_ext;

  // One extra bit keeps the extent sum exact at full-scale sizes.
  assign w_d   = (i_a >= i_b) ? {1'b0, i_a - i_b} : {1'b0, i_b - i_a};
  assign w_ext = {1'b0, i_sa} + {1'b0, i_sb};
  assign o_hit = (w_d < w_ext);

`ifdef COLLIDE_SIDE_EN
  assign o_pen    = w_ext - w_d;
  assign o_a_lt_b = (i_a < i_b);
`endif

endmodule

// File: rtl/collision_monitor.sv
// Per-frame box overlap, debounced contact FSM, entry/exit pulses and hit counter.
// Optional hit-side reporting is built when COLLIDE_SIDE_EN is defined.
module collision_monitor
  import collide_pkg::*;
#(
  parameter int COORD_W  = 10,
  parameter int DEBOUNCE = 2,
  parameter int CNT_W    = 8
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  collision_monitor_if.slave        bus,
  output state_t                    o_dbg_state
);

  localparam int DCNT_W = $clog2(DEBOUNCE + 1);

  logic w_hit_x;
  logic w_hit_y;
  logic r_overlap;

  state_t            r_state, w_state_next;
  logic [DCNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic              w_entry, w_exit;
  logic              r_enter, r_exit;
  logic [CNT_W-1:0]  r_hit_count;

`ifdef COLLIDE_SIDE_EN
  logic [COORD_W:0] w_penx, w_peny, r_penx, r_peny;
  logic             w_ax_lt, w_ay_lt, r_ax_lt, r_ay_lt;
  logic [1:0]       w_side_entry, r_side;

  axis_overlap #(.COORD_W(COORD_W)) u_axis_x (
    .i_a(bus.ax), .i_b(bus.bx), .i_sa(bus.as), .i_sb(bus.bs),
    .o_hit(w_hit_x), .o_pen(w_penx), .o_a_lt_b(w_ax_lt)
  );
  axis_overlap #(.COORD_W(COORD_W)) u_axis_y (
    .i_a(bus.ay), .i_b(bus.by), .i_sa(bus.as), .i_sb(bus.bs),
    .o_hit(w_hit_y), .o_pen(w_peny), .o_a_lt_b(w_ay_lt)
  );

  // Shallower penetration picks the axis; ties resolve to a vertical hit.
  always_comb begin
    w_side_entry = SIDE_TOP;
    if (r_penx < r_peny) w_side_entry = r_ax_lt ? SIDE_LEFT : SIDE_RIGHT;
    else                 w_side_entry = r_ay_lt ? SIDE_TOP  : SIDE_BOTTOM;
  end
`else
  axis_overlap #(.COORD_W(COORD_W)) u_axis_x (
    .i_a(bus.ax), .i_b(bus.bx), .i_sa(bus.as), .i_sb(bus.bs), .o_hit(w_hit_x)
  );
  axis_overlap #(.COORD_W(COORD_W)) u_axis_y (
    .i_a(bus.ay), .i_b(bus.by), .i_sa(bus.as), .i_sb(bus.bs), .o_hit(w_hit_y)
  );
`endif

  // Stage 1: register this frame's overlap (and penetration data for side).
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_overlap <= 1'b0;
`ifdef COLLIDE_SIDE_EN
      r_penx    <= '0;
      r_peny    <= '0;
      r_ax_lt   <= 1'b0;
      r_ay_lt   <= 1'b0;
`endif
    end else if (bus.enable) begin
      r_overlap <= w_hit_x & w_hit_y;
`ifdef COLLIDE_SIDE_EN
      r_penx    <= w_penx;
      r_peny    <= w_peny;
      r_ax_lt   <= w_ax_lt;
      r_ay_lt   <= w_ay_lt;
`endif
    end
  end

  assign w_cnt_inc = r_cnt + DCNT_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_entry      = 1'b0;
    w_exit       = 1'b0;
    case (r_state)
      FREE: begin
        if (r_overlap) begin
          if (DEBOUNCE == 1) begin
            w_state_next = CONTACT;
            w_entry      = 1'b1;
          end else begin
            w_state_next = PENDING;
            w_cnt_next   = DCNT_W'(1);
          end
        end
      end
      PENDING: begin
        if (!r_overlap) begin
          w_state_next = FREE;
          w_cnt_next   = '0;
        end else if (w_cnt_inc == DCNT_W'(DEBOUNCE)) begin
          w_state_next = CONTACT;
          w_cnt_next   = '0;
          w_entry      = 1'b1;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      CONTACT: begin
        if (!r_overlap) begin
          w_state_next = FREE;
          w_exit       = 1'b1;
        end
      end
      default: begin
        w_state_next = FREE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Pulses are registered at the transition edge, so they line up with in_contact.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= FREE;
      r_cnt       <= '0;
      r_enter     <= 1'b0;
      r_exit      <= 1'b0;
      r_hit_count <= '0;
`ifdef COLLIDE_SIDE_EN
      r_side      <= SIDE_TOP;
`endif
    end else if (bus.enable) begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_enter <= w_entry;
      r_exit  <= w_exit;
      if (bus.clear_count)
        r_hit_count <= '0;
      else if (w_entry && !(&r_hit_count))
        r_hit_count <= r_hit_count + CNT_W'(1);
`ifdef COLLIDE_SIDE_EN
      if (w_entry) r_side <= w_side_entry;
`endif
    end else begin
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
    end
  end

  assign bus.overlap     = r_overlap;
  assign bus.in_contact  = (r_state == CONTACT);
  assign bus.enter_pulse = r_enter;
  assign bus.exit_pulse  = r_exit;
  assign bus.hit_count   = r_hit_count;
`ifdef COLLIDE_SIDE_EN
  assign bus.hit_side    = r_side;
`else
  assign bus.hit_side    = 2'b00;
`endif
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_collision_monitor.sv
// Randomised and directed bench for collision_monitor against a frame-level reference model.
module tb_collision_monitor;
  import collide_pkg::*;

  localparam int COORD_W  = 10;
  localparam int DEBOUNCE = 2;
  localparam int CNT_W    = 2;
  localparam int MAXH     = (1 << CNT_W) - 1;
  localparam int EW       = 13;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg;
  always #5 clk = ~clk;

  collision_monitor_if #(.COORD_W(COORD_W), .CNT_W(CNT_W)) bus ();

  collision_monitor #(.COORD_W(COORD_W), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
    .frame_clk   (clk),
    .Reset       (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // run = number of consecutive overlapping frames seen by the contact logic, capped.
  bit m_ov, m_enter, m_exit;
  int m_run, m_hits, m_side, m_cand;

  function automatic int absdiff(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_reset();
    m_ov = 0; m_enter = 0; m_exit = 0;
    m_run = 0; m_hits = 0; m_side = 0; m_cand = 0;
  endtask

  task automatic model_edge();
    int ext, dx, dy;
    bit entry, leave;
    if (!bus.enable) begin
      m_enter = 0; m_exit = 0;
      return;
    end
    entry = 0; leave = 0;
    if (m_ov) begin
      if (m_run < DEBOUNCE) begin
        m_run++;
        entry = (m_run == DEBOUNCE);
      end
    end else begin
      leave = (m_run >= DEBOUNCE);
      m_run = 0;
    end
    if (bus.clear_count) m_hits = 0;
    else if (entry && m_hits < MAXH) m_hits++;
    if (entry) m_side = m_cand;
    m_enter = entry; m_exit = leave;
    ext = int'(bus.as) + int'(bus.bs);
    dx  = absdiff(int'(bus.ax), int'(bus.bx));
    dy  = absdiff(int'(bus.ay), int'(bus.by));
    m_ov = (dx < ext) && (dy < ext);
    if ((ext - dx) < (ext - dy)) m_cand = (bus.ax < bus.bx) ? 2 : 3;
    else                         m_cand = (bus.ay < bus.by) ? 0 : 1;
  endtask

  function automatic int exp_side();
`ifdef COLLIDE_SIDE_EN
    return m_side;
`else
    return 0;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model(string tag);
    logic [EW-1:0] e;
    exp_q.push_back({m_ov, (m_run >= DEBOUNCE), m_enter, m_exit, 7'(m_hits), 2'(exp_side())});
    e = exp_q.pop_front();
    check_eq({tag, ":overlap"},    32'(bus.overlap),     32'(e[12]));
    check_eq({tag, ":in_contact"}, 32'(bus.in_contact),  32'(e[11]));
    check_eq({tag, ":enter"},      32'(bus.enter_pulse), 32'(e[10]));
    check_eq({tag, ":exit"},       32'(bus.exit_pulse),  32'(e[9]));
    check_eq({tag, ":hit_count"},  32'(bus.hit_count),   32'(e[8:2]));
    check_eq({tag, ":hit_side"},   32'(bus.hit_side),    32'(e[1:0]));
    check_eq({tag, ":both_pulses"}, 32'(bus.enter_pulse & bus.exit_pulse), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic set_pos(int ax, int ay, int as_, int bx, int by, int bs_);
    bus.ax = COORD_W'(ax); bus.ay = COORD_W'(ay); bus.as = COORD_W'(as_);
    bus.bx = COORD_W'(bx); bus.by = COORD_W'(by); bus.bs = COORD_W'(bs_);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_model("reset");
    step("reset_hold");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.enable = 1'b1;
    bus.clear_count = 1'b0;
    set_pos(0, 0, 0, 500, 500, 0);
    apply_reset();

    // Entry after two overlapping frames; LEFT side when side reporting exists.
    set_pos(100, 100, 5, 108, 100, 5);
    step("t1_n");
    check_eq("t1_overlap_n", 32'(bus.overlap), 32'd1);
    step("t1_n1");
    check_eq("t1_pending", 32'(bus.in_contact), 32'd0);
    step("t1_n2");
    check_eq("t1_enter", 32'(bus.enter_pulse), 32'd1);
    check_eq("t1_count", 32'(bus.hit_count), 32'd1);
    step("t1_hold");

    // Exit on separation, count unchanged.
    set_pos(200, 200, 5, 108, 100, 5);
    step("t4_a");
    step("t4_b");
    check_eq("t4_exit", 32'(bus.exit_pulse), 32'd1);
    step("t4_c");

    // Touching edges are not overlap.
    set_pos(90, 100, 5, 100, 100, 5);
    repeat (3) step("t2_touch");
    check_eq("t2_overlap", 32'(bus.overlap), 32'd0);

    // Single overlapping frame never reaches contact.
    set_pos(100, 100, 5, 104, 102, 5);
    step("t3_a");
    set_pos(300, 100, 5, 104, 102, 5);
    repeat (3) step("t3_b");

    // Full-scale extents need the extra sum bit.
    set_pos(1023, 0, 1023, 0, 1023, 1023);
    step("wide_a");
    check_eq("wide_overlap", 32'(bus.overlap), 32'd1);
    set_pos(1023, 0, 511, 0, 0, 512);
    step("wide_touch");
    check_eq("wide_touch_ov", 32'(bus.overlap), 32'd0);

    // Saturation of the hit counter, then clear.
    for (int k = 0; k < 5; k++) begin
      set_pos(50, 60, 8, 55, 52, 8);
      repeat (3) step("t5_in");
      set_pos(400, 60, 8, 55, 52, 8);
      repeat (2) step("t5_out");
    end
    check_eq("t5_saturated", 32'(bus.hit_count), 32'(MAXH));
    bus.clear_count = 1'b1;
    step("t5_clear");
    bus.clear_count = 1'b0;
    check_eq("t5_cleared", 32'(bus.hit_count), 32'd0);

    // Freeze during PENDING, then resume into CONTACT.
    set_pos(100, 100, 5, 100, 95, 5);
    step("t6_ov");
    step("t6_pend");
    bus.enable = 1'b0;
    repeat (3) step("t6_frozen");
    check_eq("t6_frozen_contact", 32'(bus.in_contact), 32'd0);
    bus.enable = 1'b1;
    step("t6_resume");
    check_eq("t6_enter", 32'(bus.enter_pulse), 32'd1);
    step("t6_contact");

    // Reset while in contact: outputs drop at once, no exit pulse afterwards.
    apply_reset();
    step("t6_after_rst");
    check_eq("t6_no_exit", 32'(bus.exit_pulse), 32'd0);

    // Randomised frames: clustered positions with runs of held frames.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 35)
        set_pos($urandom_range(480, 540), $urandom_range(480, 540), $urandom_range(0, 20),
                $urandom_range(480, 540), $urandom_range(480, 540), $urandom_range(0, 20));
      bus.enable      = ($urandom_range(0, 99) >= 15);
      bus.clear_count = bus.enable && ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 299) == 0) apply_reset();
      step("rand");
    end
    bus.clear_count = 1'b0;
    bus.enable = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
